// File: rtl/fpu_div_half_if.sv
// Request/response bundle for the binary16 divider: operands and rounding
// mode in, busy/done handshake plus quotient and fflags out.
interface fpu_div_half_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  rm;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [4:0]  flags;

  modport master (output start, a, b, rm, input busy, done, result, flags);
  modport slave  (input start, a, b, rm, output busy, done, result, flags);
endinterface

// File: rtl/fpu_div_half.sv
// Iterative radix-2 restoring binary16 divider with RISC-V fflags.
// FPU_DIV_EARLY_OUT_EN: special operands skip DIV/ROUND and finish at cycle 2.
module fpu_div_half #(
  parameter int unsigned ITER = 13
) (
  input logic           CLK,
  input logic           RST,
  fpu_div_half_if.slave io
);

  localparam int unsigned CW = $clog2(ITER + 1);
  localparam int unsigned RW = 13;
  localparam logic signed [6:0] ITER_S = 7'(ITER);
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  typedef logic [4:0] exp_t;
  typedef logic [9:0] mant_t;
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_ROUND, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        a_q, a_d, b_q, b_d;
  logic [2:0]         rm_q, rm_d;
  logic               sign_q, sign_d;
  logic signed [6:0]  e_q, e_d;
  logic [RW-1:0]      rem_q, rem_d;
  logic [10:0]        dvs_q, dvs_d;
  logic [ITER-1:0]    quo_q, quo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               spec_q, spec_d;
  logic [15:0]        spec_res_q, spec_res_d;
  logic [4:0]         spec_flg_q, spec_flg_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [15:0]        result_q, result_d;
  logic [4:0]         flags_q, flags_d;

  function automatic logic [3:0] lzc11(input logic [10:0] m);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i <= 10; i++) begin
      if (m[i]) n = 4'(10 - i);
    end
    return n;
  endfunction

  // Operand classification, subnormal normalization and special-case result
  exp_t              ea_raw, eb_raw;
  mant_t             fa, fb;
  logic              a_zero, a_inf, a_nan, a_snan, b_zero, b_inf, b_nan, b_snan;
  logic [10:0]       ma, mb, ma_n, mb_n;
  logic [3:0]        lza, lzb;
  logic signed [6:0] ea, eb, e_pre;
  logic              sign_pre, is_spec;
  logic [15:0]       spec_res;
  logic [4:0]        spec_flg;

  always_comb begin
    ea_raw   = a_q[14:10];
    eb_raw   = b_q[14:10];
    fa       = a_q[9:0];
    fb       = b_q[9:0];
    a_zero   = (ea_raw == 5'd0) && (fa == 10'd0);
    b_zero   = (eb_raw == 5'd0) && (fb == 10'd0);
    a_inf    = (&ea_raw) && (fa == 10'd0);
    b_inf    = (&eb_raw) && (fb == 10'd0);
    a_nan    = (&ea_raw) && (|fa);
    b_nan    = (&eb_raw) && (|fb);
    a_snan   = a_nan && !fa[9];
    b_snan   = b_nan && !fb[9];
    ma       = {|ea_raw, fa};
    mb       = {|eb_raw, fb};
    lza      = (ea_raw == 5'd0) ? lzc11(ma) : 4'd0;
    lzb      = (eb_raw == 5'd0) ? lzc11(mb) : 4'd0;
    ma_n     = ma << lza;
    mb_n     = mb << lzb;
    ea       = 7'({2'b00, (ea_raw == 5'd0) ? 5'd1 : ea_raw}) - 7'({3'b000, lza});
    eb       = 7'({2'b00, (eb_raw == 5'd0) ? 5'd1 : eb_raw}) - 7'({3'b000, lzb});
    e_pre    = ea - eb + 7'sd15;
    sign_pre = a_q[15] ^ b_q[15];
    is_spec  = 1'b1;
    spec_res = 16'h7E00;
    spec_flg = 5'b00000;
    if (a_nan || b_nan) begin
      spec_flg = {a_snan || b_snan, 4'b0000};
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_flg = 5'b10000;
    end else if (a_inf) begin
      spec_res = {sign_pre, 15'h7C00};
    end else if (b_zero) begin
      spec_res = {sign_pre, 15'h7C00};
      spec_flg = 5'b01000;
    end else if (a_zero || b_inf) begin
      spec_res = {sign_pre, 15'h0000};
    end else begin
      is_spec  = 1'b0;
    end
  end

  // Normalize quotient, denormalize tiny results, round and detect overflow
  logic [ITER-1:0]     qn, mq;
  logic signed [6:0]   en, sh7;
  logic [6:0]          shamt;
  logic [2*ITER-1:0]   wide;
  logic                tiny, g, st, lsb, inexact, rnd_inc, ovf;
  logic [9:0]          frac;
  logic [4:0]          exp_f;
  logic [15:0]         mag_r, rnd_res;
  logic [4:0]          rnd_flg;

  always_comb begin
    qn      = quo_q[ITER-1] ? quo_q : {quo_q[ITER-2:0], 1'b0};
    en      = quo_q[ITER-1] ? e_q : e_q - 7'sd1;
    tiny    = en < 7'sd1;
    sh7     = 7'sd1 - en;
    shamt   = !tiny ? 7'd0 : ((sh7 > ITER_S) ? 7'(ITER) : sh7);
    wide    = {qn, {ITER{1'b0}}} >> shamt;
    mq      = wide[2*ITER-1 -: ITER];
    frac    = mq[ITER-2 -: 10];
    lsb     = mq[ITER-11];
    g       = mq[ITER-12];
    st      = (|wide[ITER-1:0]) | (|mq[ITER-13:0]) | (|rem_q);
    inexact = g | st;
    case (rm_q)
      RM_RTZ:  rnd_inc = 1'b0;
      RM_RDN:  rnd_inc = sign_q & inexact;
      RM_RUP:  rnd_inc = !sign_q & inexact;
      RM_RMM:  rnd_inc = g;
      default: rnd_inc = g & (st | lsb);
    endcase
    exp_f   = tiny ? 5'd0 : en[4:0];
    mag_r   = 16'({1'b0, exp_f, frac}) + 16'(rnd_inc);
    ovf     = (!tiny && (en > 7'sd30)) || (&mag_r[14:10]);
    rnd_res = {sign_q, mag_r[14:0]};
    rnd_flg = {3'b000, tiny & inexact, inexact};
    if (ovf) begin
      rnd_flg = 5'b00101;
      case (rm_q)
        RM_RTZ:  rnd_res = {sign_q, 15'h7BFF};
        RM_RDN:  rnd_res = sign_q ? 16'hFC00 : 16'h7BFF;
        RM_RUP:  rnd_res = sign_q ? 16'hFBFF : 16'h7C00;
        default: rnd_res = {sign_q, 15'h7C00};
      endcase
    end
  end

  // Next-state and datapath update
  logic [RW-1:0] trial;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    rm_d       = rm_q;
    sign_d     = sign_q;
    e_d        = e_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_flg_d = spec_flg_q;
    result_d   = result_q;
    flags_d    = flags_q;
    trial      = rem_q - {2'b00, dvs_q};
    case (state_q)
      S_IDLE: begin
        if (io.start) begin
          a_d     = io.a;
          b_d     = io.b;
          rm_d    = (io.rm > 3'd4) ? RM_RNE : io.rm;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        sign_d     = sign_pre;
        e_d        = e_pre;
        rem_d      = {2'b00, ma_n};
        dvs_d      = mb_n;
        quo_d      = '0;
        cnt_d      = '0;
        spec_d     = is_spec;
        spec_res_d = spec_res;
        spec_flg_d = spec_flg;
        state_d    = S_DIV;
`ifdef FPU_DIV_EARLY_OUT_EN
        if (is_spec) begin
          result_d = spec_res;
          flags_d  = spec_flg;
          state_d  = S_DONE;
        end
`endif
      end
      S_DIV: begin
        rem_d = trial[RW-1] ? {rem_q[RW-2:0], 1'b0} : {trial[RW-2:0], 1'b0};
        quo_d = {quo_q[ITER-2:0], !trial[RW-1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d = spec_q ? spec_res_q : rnd_res;
        flags_d  = spec_q ? spec_flg_q : rnd_flg;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      rm_q       <= '0;
      sign_q     <= 1'b0;
      e_q        <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_flg_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rm_q       <= rm_d;
      sign_q     <= sign_d;
      e_q        <= e_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_flg_q <= spec_flg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign io.busy   = busy_q;
  assign io.done   = done_q;
  assign io.result = result_q;
  assign io.flags  = flags_q;

endmodule

// File: tb/tb_fpu_div_half.sv
// Scoreboard bench for fpu_div_half: directed vectors push expected result,
// flags and done cycle; a negedge monitor pops and compares on each done.
module tb_fpu_div_half;

  localparam int LAT_NORM = 16;
`ifdef FPU_DIV_EARLY_OUT_EN
  localparam int LAT_SPEC = 2;
`else
  localparam int LAT_SPEC = 16;
`endif
  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3;

  typedef struct {
    int          id;
    logic [15:0] res;
    logic [4:0]  flg;
    int          cyc;
  } sb_ent_t;

  logic    clk = 1'b0;
  logic    rst;
  int      cyc = 0;
  int      n_chk = 0;
  int      n_pass = 0;
  sb_ent_t sb[$];
  sb_ent_t mon_e;
  sb_ent_t drn_e;

  fpu_div_half_if io ();

  fpu_div_half dut (
    .CLK (clk),
    .RST (rst),
    .io  (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s op%0d: got %h expected %h", nm, id, act, exp);
  endtask

  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input logic [2:0] rm,
                       input logic [15:0] res, input logic [4:0] flg, input bit spec);
    sb_ent_t e;
    @(posedge clk); #1;
    io.start = 1'b1;
    io.a     = a;
    io.b     = b;
    io.rm    = rm;
    e.id  = id;
    e.res = res;
    e.flg = flg;
    e.cyc = cyc + (spec ? LAT_SPEC : LAT_NORM);
    sb.push_back(e);
    @(posedge clk); #1;
    io.start = 1'b0;
    io.a     = 16'h7E00;
    io.b     = 16'h0000;
    io.rm    = RUP;
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (io.busy && n < 40);
    if (io.busy) begin
      n_chk++;
      $display("FAIL idle_timeout op%0d: busy still 1 after %0d cycles, expected 0", id, n);
    end
  endtask

  task automatic run(input int id, input logic [15:0] a, input logic [15:0] b, input logic [2:0] rm,
                     input logic [15:0] res, input logic [4:0] flg, input bit spec);
    issue(id, a, b, rm, res, flg, spec);
    wait_idle(id);
  endtask

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (io.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 expected done=0", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result", mon_e.id, 32'(io.result), 32'(mon_e.res));
        chk("flags", mon_e.id, 32'(io.flags), 32'(mon_e.flg));
        chk("done_cycle", mon_e.id, 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    int bad;
    int n;
    rst      = 1'b1;
    io.start = 1'b0;
    io.a     = 16'h0000;
    io.b     = 16'h0000;
    io.rm    = RNE;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 0, 32'(io.busy), 32'd0);
    chk("rst_done", 0, 32'(io.done), 32'd0);
    chk("rst_result", 0, 32'(io.result), 32'h0);
    chk("rst_flags", 0, 32'(io.flags), 32'h0);

    // busy must cover cycles 1..16 exactly
    issue(1, 16'h3C00, 16'h3C00, RNE, 16'h3C00, 5'h00, 1'b0);
    bad = 0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (io.busy !== (k <= 16)) bad++;
    end
    chk("busy_window", 1, 32'(bad), 32'd0);

    run(2,  16'h3C00, 16'h4200, RNE,    16'h3555, 5'h01, 1'b0);
    run(3,  16'h3C00, 16'h4200, RTZ,    16'h3555, 5'h01, 1'b0);
    run(4,  16'h3C00, 16'h4200, RUP,    16'h3556, 5'h01, 1'b0);
    run(5,  16'h3C00, 16'h4200, RDN,    16'h3555, 5'h01, 1'b0);
    run(6,  16'h3C00, 16'h4200, 3'd7,   16'h3555, 5'h01, 1'b0);
    run(7,  16'h3C00, 16'h0000, RNE,    16'h7C00, 5'h08, 1'b1);
    run(8,  16'h0000, 16'h0000, RNE,    16'h7E00, 5'h10, 1'b1);
    run(9,  16'h7C01, 16'h3C00, RNE,    16'h7E00, 5'h10, 1'b1);
    run(10, 16'hBC00, 16'h7C00, RNE,    16'h8000, 5'h00, 1'b1);
    run(11, 16'h7BFF, 16'h1400, RNE,    16'h7C00, 5'h05, 1'b0);
    run(12, 16'h7BFF, 16'h1400, RTZ,    16'h7BFF, 5'h05, 1'b0);
    run(13, 16'hFBFF, 16'h1400, RDN,    16'hFC00, 5'h05, 1'b0);
    run(14, 16'h0400, 16'h4000, RNE,    16'h0200, 5'h00, 1'b0);
    run(15, 16'h0001, 16'h4000, RNE,    16'h0000, 5'h03, 1'b0);
    run(16, 16'h0001, 16'h4000, RUP,    16'h0001, 5'h03, 1'b0);

    // start pulsed at cycle 5 of an operation must be dropped
    issue(20, 16'h3C00, 16'h3C00, RNE, 16'h3C00, 5'h00, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    io.start = 1'b1;
    io.a     = 16'h0000;
    io.b     = 16'h0000;
    @(posedge clk); #1;
    io.start = 1'b0;
    wait_idle(20);
    repeat (20) @(negedge clk);
    chk("ignored_start_idle", 20, 32'(io.busy), 32'd0);

    // reset at cycle 8 aborts the operation without a done
    @(posedge clk); #1;
    io.start = 1'b1;
    io.a     = 16'h3C00;
    io.b     = 16'h4200;
    io.rm    = RNE;
    @(posedge clk); #1;
    io.start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 21, 32'(io.busy), 32'd0);
    chk("abort_done", 21, 32'(io.done), 32'd0);
    chk("abort_result", 21, 32'(io.result), 32'h0);
    chk("abort_flags", 21, 32'(io.flags), 32'h0);
    repeat (20) @(negedge clk);

    run(30, 16'h3C00, 16'h4200, RUP, 16'h3556, 5'h01, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    while (sb.size() != 0) begin
      drn_e = sb.pop_front();
      n_chk++;
      $display("FAIL missing_done op%0d: got no done, expected done at cycle %0d", drn_e.id, drn_e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
